// File: rtl/paper_pkg.sv
// paper_pkg: shared state encoding, page size and burst request type for the fetch scheduler
package paper_pkg;
  localparam int PageBytes = 4096;
  typedef enum logic [1:0] {IDLE, WAIT_FRAME, ISSUE, DRAIN} state_e;
  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
  } burst_req_t;
endpackage

// File: rtl/paper_burst_calc.sv
// paper_burst_calc: beats in the next burst, clamped to MaxBurst, the line remainder and the 4 KiB page
module paper_burst_calc
  import paper_pkg::*;
#(
  parameter int BeatBytes = 8,
  parameter int MaxBurst  = 16
) (
  input  logic [11:0] page_off,
  input  logic [16:0] beats_left,
  output logic [8:0]  beats
);
  logic [12:0] page_beats;
  logic [8:0]  line_clamp;
  always_comb begin
    page_beats = (13'(PageBytes) - {1'b0, page_off}) >> $clog2(BeatBytes);
    line_clamp = beats_left < 17'(MaxBurst) ? beats_left[8:0] : 9'(MaxBurst);
    beats = page_beats < {4'b0, line_clamp} ? page_beats[8:0] : line_clamp;
  end
endmodule

// File: rtl/paper_fetch_sched.sv
// paper_fetch_sched: turns a frame configuration into AXI4 AR bursts, gated by FIFO credit
// and an outstanding-burst limit, tracking returning R beats.
module paper_fetch_sched
  import paper_pkg::*;
#(
  parameter int AxiAddrWidth   = 64,
  parameter int AxiDataWidth   = 64,
  parameter int AxiIdWidth     = 4,
  parameter int AxiArId        = 1337,
  parameter int FifoDepth      = 256,
  parameter int MaxBurst       = 16,
  parameter int MaxOutstanding = 4
) (
  input  logic                          axi_clk_i,
  input  logic                          rst_ni,
  input  logic                          cfg_en_i,
  input  logic [AxiAddrWidth-1:0]       cfg_base_i,
  input  logic [31:0]                   cfg_stride_i,
  input  logic [15:0]                   cfg_line_beats_i,
  input  logic [15:0]                   cfg_lines_i,
  input  logic                          frame_start_i,
  input  logic [$clog2(FifoDepth):0]    fifo_fill_i,
  output logic                          ar_valid_o,
  input  logic                          ar_ready_i,
  output logic [AxiAddrWidth-1:0]       ar_addr_o,
  output logic [7:0]                    ar_len_o,
  output logic [AxiIdWidth-1:0]         ar_id_o,
  input  logic                          r_beat_i,
  input  logic                          r_last_i,
  output logic                          busy_o,
  output logic                          frame_done_o,
  output logic                          err_late_o
);
  localparam int CW    = $clog2(FifoDepth) + 2;
  localparam int OW    = $clog2(MaxOutstanding) + 1;
  localparam int Shift = $clog2(AxiDataWidth / 8);
  state_e state, state_d;
  logic [AxiAddrWidth-1:0] cur_addr, line_addr;
  logic [31:0] stride;
  logic [15:0] line_beats, lines, line, beat;
  logic [CW-1:0] inflight, inf_add;
  logic [OW-1:0] outstanding, out_add;
  burst_req_t req;
  logic [8:0] calc_beats, beats;
  logic [16:0] beat_n;
  logic hs, eol, last, credit;
  paper_burst_calc #(.BeatBytes(AxiDataWidth / 8), .MaxBurst(MaxBurst)) u_calc (
    .page_off  (cur_addr[11:0]),
    .beats_left({1'b0, line_beats} - {1'b0, beat}),
    .beats     (calc_beats)
  );
  assign ar_addr_o = req.addr[AxiAddrWidth-1:0];
  assign ar_len_o  = req.len;
  assign ar_id_o   = AxiIdWidth'(AxiArId);
  always_comb begin
    hs      = ar_valid_o && ar_ready_i;
    beats   = {1'b0, req.len} + 9'd1;
    beat_n  = {1'b0, beat} + {8'b0, beats};
    eol     = beat_n == {1'b0, line_beats};
    last    = eol && (line + 16'd1 == lines);
    credit  = (CW'(fifo_fill_i) + inflight + CW'(calc_beats) <= CW'(FifoDepth)) &&
              (outstanding < OW'(MaxOutstanding));
    inf_add = inflight + (hs ? CW'(beats) : CW'(0));
    out_add = outstanding + OW'(hs);
    state_d = state;
    unique case (state)
      IDLE:       state_d = cfg_en_i ? WAIT_FRAME : IDLE;
      WAIT_FRAME: state_d = !cfg_en_i ? IDLE : !frame_start_i ? WAIT_FRAME :
                            (cfg_lines_i == 16'd0 || cfg_line_beats_i == 16'd0) ? DRAIN : ISSUE;
      ISSUE:      state_d = ((hs && last) || (!cfg_en_i && (hs || !ar_valid_o))) ? DRAIN : ISSUE;
      DRAIN:      state_d = outstanding != '0 ? DRAIN : cfg_en_i ? WAIT_FRAME : IDLE;
      default:    state_d = IDLE;
    endcase
  end
  always_ff @(posedge axi_clk_i) begin
    if (!rst_ni) begin
      state        <= IDLE;
      ar_valid_o   <= 1'b0;
      req          <= '0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
      err_late_o   <= 1'b0;
      cur_addr     <= '0;
      line_addr    <= '0;
      stride       <= '0;
      line_beats   <= '0;
      lines        <= '0;
      line         <= '0;
      beat         <= '0;
      inflight     <= '0;
      outstanding  <= '0;
    end else begin
      state        <= state_d;
      busy_o       <= state_d == ISSUE || state_d == DRAIN;
      frame_done_o <= state == DRAIN && outstanding == '0;
      err_late_o   <= frame_start_i && (state == ISSUE || state == DRAIN);
      // R returns after a reset can outnumber what is tracked, so both counters floor at 0
      inflight     <= (r_beat_i && inf_add != '0) ? inf_add - CW'(1) : inf_add;
      outstanding  <= (r_beat_i && r_last_i && out_add != '0) ? out_add - OW'(1) : out_add;
      if (state == WAIT_FRAME && cfg_en_i && frame_start_i) begin
        cur_addr   <= cfg_base_i;
        line_addr  <= cfg_base_i;
        stride     <= cfg_stride_i;
        line_beats <= cfg_line_beats_i;
        lines      <= cfg_lines_i;
        line       <= '0;
        beat       <= '0;
      end
      if (state == ISSUE && !ar_valid_o && cfg_en_i && credit) begin
        ar_valid_o <= 1'b1;
        req        <= '{addr: 64'(cur_addr), len: 8'(calc_beats - 9'd1)};
      end
      if (hs) begin
        ar_valid_o <= 1'b0;
        beat       <= eol ? 16'd0 : beat_n[15:0];
        line       <= eol ? line + 16'd1 : line;
        line_addr  <= eol ? line_addr + AxiAddrWidth'(stride) : line_addr;
        cur_addr   <= eol ? line_addr + AxiAddrWidth'(stride) : cur_addr + (AxiAddrWidth'(beats) << Shift);
      end
    end
  end
endmodule

// File: tb/tb_paper_fetch_sched.sv
// tb_paper_fetch_sched: directed frames against a burst-list model and an R responder
module tb_paper_fetch_sched;
  typedef struct {
    logic [63:0] a;
    logic [7:0]  l;
  } burst_t;
  logic        clk = 0;
  logic        rst_n, cfg_en, frame_start, ar_ready, r_beat, r_last, r_en;
  logic [63:0] cfg_base;
  logic [31:0] cfg_stride;
  logic [15:0] cfg_line_beats, cfg_lines;
  logic [8:0]  fifo_fill;
  logic        ar_valid, busy, frame_done, err_late;
  logic [63:0] ar_addr;
  logic [7:0]  ar_len;
  logic [3:0]  ar_id;
  burst_t expq[$];
  burst_t got[$];
  int hs_cyc[$];
  int rq[$];
  int vectors = 0, fails = 0, n_ar = 0, n_done = 0, n_err = 0, cyc = 0;
  logic prev_v = 0, prev_r = 0;
  paper_fetch_sched dut (
    .axi_clk_i(clk), .rst_ni(rst_n), .cfg_en_i(cfg_en), .cfg_base_i(cfg_base),
    .cfg_stride_i(cfg_stride), .cfg_line_beats_i(cfg_line_beats), .cfg_lines_i(cfg_lines),
    .frame_start_i(frame_start), .fifo_fill_i(fifo_fill), .ar_valid_o(ar_valid),
    .ar_ready_i(ar_ready), .ar_addr_o(ar_addr), .ar_len_o(ar_len), .ar_id_o(ar_id),
    .r_beat_i(r_beat), .r_last_i(r_last), .busy_o(busy), .frame_done_o(frame_done),
    .err_late_o(err_late)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask
  // Expected burst list straight from the address arithmetic: walk each line, cut at 16 beats or 4 KiB
  task automatic build(input logic [63:0] base, input int stride, input int lb, input int lines);
    logic [63:0] a;
    int left, n, pg;
    expq.delete();
    for (int l = 0; l < lines; l++) begin
      a = base + 64'(l) * 64'(stride);
      left = lb;
      while (left > 0) begin
        pg = (4096 - int'(a % 4096)) / 8;
        n = 16;
        if (left < n) n = left;
        if (pg < n) n = pg;
        expq.push_back('{a, 8'(n - 1)});
        a += 64'(n * 8);
        left -= n;
      end
    end
  endtask
  task automatic start(input logic [63:0] base, input int stride, input int lb, input int lines);
    @(negedge clk);
    cfg_base = base;
    cfg_stride = stride;
    cfg_line_beats = 16'(lb);
    cfg_lines = 16'(lines);
    build(base, stride, lb, lines);
    frame_start = 1;
    @(negedge clk);
    frame_start = 0;
  endtask
  task automatic wait_done(input int lim);
    int d0;
    d0 = n_done;
    for (int i = 0; i < lim && n_done == d0; i++) @(posedge clk);
    chk("frame_done_seen", 64'(n_done > d0), 1);
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_v && !prev_r) chk("ar_hold", ar_valid, 1);
      if (ar_valid) begin
        if (expq.size() == 0) chk("unexpected_ar", ar_addr, 64'hdead);
        else begin
          chk("ar_addr", ar_addr, expq[0].a);
          chk("ar_len", 64'(ar_len), 64'(expq[0].l));
        end
        if (ar_ready) begin
          got.push_back('{ar_addr, ar_len});
          hs_cyc.push_back(cyc);
          if (expq.size() > 0) void'(expq.pop_front());
          n_ar++;
        end
      end
      if (frame_done) n_done++;
      if (err_late) n_err++;
    end
    prev_v = ar_valid && rst_n;
    prev_r = ar_ready;
  end
  // R responder: one beat per cycle for bursts accepted at earlier edges
  initial begin
    logic hs_now;
    r_beat = 0;
    r_last = 0;
    forever begin
      @(negedge clk);
      if (r_beat) begin
        rq[0]--;
        if (rq[0] == 0) void'(rq.pop_front());
      end
      hs_now = ar_valid && ar_ready && rst_n;
      r_beat = r_en && rq.size() > 0;
      r_last = r_beat && rq[0] == 1;
      if (hs_now) rq.push_back(int'(ar_len) + 1);
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int a0, d0, e0;
    rst_n = 0; cfg_en = 0; frame_start = 0; ar_ready = 1; r_en = 1; fifo_fill = 0;
    cfg_base = 0; cfg_stride = 0; cfg_line_beats = 0; cfg_lines = 0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(ar_valid), 0);
    chk("rst_addr", ar_addr, 0);
    chk("rst_len", 64'(ar_len), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(frame_done), 0);
    chk("rst_err", 64'(err_late), 0);
    chk("ar_id", 64'(ar_id), 9);
    rst_n = 1;
    cfg_en = 1;
    repeat (2) @(negedge clk);
    // two 640-beat lines: 80 aligned 16-beat bursts
    a0 = n_ar; d0 = n_done; got.delete(); hs_cyc.delete();
    start(64'h8000_0000, 5120, 640, 2);
    chk("t1_valid_k1", 64'(ar_valid), 0);
    chk("t1_busy_k1", 64'(busy), 1);
    @(negedge clk);
    chk("t1_valid_k2", 64'(ar_valid), 1);
    wait_done(3000);
    repeat (4) @(negedge clk);
    chk("t1_bursts", 64'(n_ar - a0), 80);
    chk("t1_done_once", 64'(n_done - d0), 1);
    chk("t1_model_drained", 64'(expq.size()), 0);
    chk("t1_last_addr", got[79].a, 64'h8000_2780);
    chk("t1_last_len", 64'(got[79].l), 15);
    chk("t1_gap1", 64'(hs_cyc[1] - hs_cyc[0]), 2);
    chk("t1_gap2", 64'(hs_cyc[2] - hs_cyc[1]), 2);
    chk("t1_busy_after", 64'(busy), 0);
    // 4 KiB split
    got.delete();
    start(64'h8000_0FC0, 0, 20, 1);
    wait_done(200);
    chk("t2_count", 64'(got.size()), 2);
    chk("t2_addr0", got[0].a, 64'h8000_0FC0);
    chk("t2_len0", 64'(got[0].l), 7);
    chk("t2_addr1", got[1].a, 64'h8000_1000);
    chk("t2_len1", 64'(got[1].l), 11);
    // FIFO credit
    fifo_fill = 250; a0 = n_ar;
    start(64'h1000, 0, 64, 1);
    repeat (10) @(negedge clk);
    chk("t3_blocked_valid", 64'(ar_valid), 0);
    chk("t3_blocked_count", 64'(n_ar - a0), 0);
    fifo_fill = 240;
    @(negedge clk);
    chk("t3_released", 64'(ar_valid), 1);
    @(negedge clk);
    fifo_fill = 0;
    wait_done(400);
    chk("t3_bursts", 64'(n_ar - a0), 4);
    // outstanding limit
    r_en = 0; a0 = n_ar;
    start(64'h2000, 0, 64, 2);
    repeat (30) @(negedge clk);
    chk("t4_four", 64'(n_ar - a0), 4);
    chk("t4_stalled", 64'(ar_valid), 0);
    r_en = 1;
    for (int i = 0; i < 60 && n_ar - a0 < 5; i++) @(negedge clk);
    chk("t4_fifth", 64'(n_ar - a0), 5);
    wait_done(600);
    chk("t4_bursts", 64'(n_ar - a0), 8);
    // late frame_start
    a0 = n_ar; e0 = n_err;
    start(64'h4000, 0, 64, 2);
    repeat (3) @(negedge clk);
    frame_start = 1;
    @(negedge clk);
    frame_start = 0;
    wait_done(600);
    repeat (2) @(negedge clk);
    chk("t5_err_once", 64'(n_err - e0), 1);
    chk("t5_bursts", 64'(n_ar - a0), 8);
    chk("t5_model_drained", 64'(expq.size()), 0);
    // empty frame
    a0 = n_ar;
    start(64'h5000, 0, 16, 0);
    chk("t6_done_k1", 64'(frame_done), 0);
    chk("t6_busy_k1", 64'(busy), 1);
    @(negedge clk);
    chk("t6_done_k2", 64'(frame_done), 1);
    @(negedge clk);
    chk("t6_done_k3", 64'(frame_done), 0);
    chk("t6_no_ar", 64'(n_ar - a0), 0);
    // reset mid-frame with R beats still pending
    a0 = n_ar;
    start(64'h6000, 0, 640, 1);
    for (int i = 0; i < 40 && n_ar - a0 < 3; i++) @(negedge clk);
    @(negedge clk);
    ar_ready = 0;
    rst_n = 0;
    @(negedge clk);
    chk("t7_valid_after_rst", 64'(ar_valid), 0);
    chk("t7_busy_after_rst", 64'(busy), 0);
    expq.delete();
    rst_n = 1;
    @(negedge clk);
    chk("t7_idle", 64'(busy), 0);
    for (int i = 0; i < 100 && rq.size() > 0; i++) @(negedge clk);
    chk("t7_stale_drained", 64'(rq.size()), 0);
    ar_ready = 1;
    start(64'h7000, 0, 16, 1);
    @(negedge clk);
    chk("t7_restart_valid", 64'(ar_valid), 1);
    wait_done(200);
    chk("t7_model_drained", 64'(expq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
